// File: rtl/spm_rmw_bridge.sv
// Core-side byte-enabled request port to full-word SPM port; partial writes are
// turned into a read-modify-write sequence.
module spm_rmw_bridge #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    io_C_Valid,
   output logic                    io_C_Ready,
   input  logic                    io_C_We,
   input  logic [ADDR_WIDTH-1:0]   io_C_Addr,
   input  logic [DATA_WIDTH-1:0]   io_C_Data,
   input  logic [DATA_WIDTH/8-1:0] io_C_ByteEn,
   output logic                    io_C_RespValid,
   output logic [DATA_WIDTH-1:0]   io_C_RespData,
   output logic [DATA_WIDTH-1:0]   io_M_Data,
   output logic [ADDR_WIDTH-1:0]   io_M_Addr,
   output logic [DATA_WIDTH/8-1:0] io_M_ByteEn,
   output logic                    io_M_We,
   input  logic [DATA_WIDTH-1:0]   io_S_Data
);

   localparam int unsigned LANES = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RMW_RD,
      RMW_WR,
      ACK
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  req_addr_q;
   logic [DATA_WIDTH-1:0]  req_data_q;
   logic [LANES-1:0]       req_be_q;
   logic [DATA_WIDTH-1:0]  resp_q;
   logic                   accept;
   logic                   m_we;
   logic [ADDR_WIDTH-1:0]  m_addr;
   logic [DATA_WIDTH-1:0]  m_data;
   logic [DATA_WIDTH-1:0]  merged;

   assign accept = io_C_Valid && (state_q == IDLE);

   // State, captured request fields and response data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         req_addr_q <= '0;
         req_data_q <= '0;
         req_be_q   <= '0;
         resp_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            req_addr_q <= io_C_Addr;
            req_data_q <= io_C_Data;
            req_be_q   <= io_C_ByteEn;
            if (io_C_We) resp_q <= '0;
         end
         if (state_q == RD_WAIT) resp_q <= io_S_Data;
      end
   end

   // Next state and M-port drive; IDLE passes the C port straight through
   always_comb begin
      state_d = state_q;
      m_we    = 1'b0;
      m_addr  = req_addr_q;
      m_data  = req_data_q;
      merged  = io_S_Data;
      for (int i = 0; i < int'(LANES); i++) begin
         if (req_be_q[i]) merged[8*i +: 8] = req_data_q[8*i +: 8];
      end
      case (state_q)
         IDLE: begin
            m_addr = io_C_Addr;
            m_data = io_C_Data;
            if (accept) begin
               if (!io_C_We) begin
                  state_d = RD_WAIT;
               end else if (io_C_ByteEn == {LANES{1'b1}}) begin
                  m_we    = 1'b1;
                  state_d = ACK;
               end else if (io_C_ByteEn == '0) begin
                  state_d = ACK;
               end else begin
                  state_d = RMW_RD;
               end
            end
         end
         RD_WAIT: state_d = ACK;
         RMW_RD: begin
            m_we    = 1'b1;
            m_data  = merged;
            state_d = RMW_WR;
         end
         RMW_WR:  state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Reset gates the strobe so an interrupted RMW can never commit
   assign io_M_We        = m_we && reset;
   assign io_M_ByteEn    = {LANES{io_M_We}};
   assign io_M_Addr      = m_addr;
   assign io_M_Data      = m_data;
   assign io_C_Ready     = (state_q == IDLE);
   assign io_C_RespValid = (state_q == ACK);
   assign io_C_RespData  = resp_q;

endmodule
